// File: rtl/ir_cmd_scheduler.sv
// Purpose : validate NEC frames, suppress key-repeat, queue commands in a 4-deep FIFO, and watchdog the decoder.
// Latency : 3 cycles from new_code_in to cmd_valid_out when the FIFO is empty.
// Backpressure: cmd_valid_out/cmd_ready_in handshake. Frames arriving while the FIFO is full are dropped and counted.
//
// Ports:
//   clk_in, rst_in             clock and synchronous active-high reset
//   code_in, new_code_in       decoded frame {addr, ~addr, cmd, ~cmd} and its strobe
//   dec_state_in               decoder FSM state (0 = idle), watched by the watchdog
//   cmd_out, cmd_valid_out,
//   cmd_ready_in               command stream out of the FIFO
//   err_count_out              saturating count of malformed / foreign-address frames
//   drop_count_out             saturating count of good frames that were lost
//   dec_rst_out                one-cycle decoder reset when the decoder is stuck
module ir_cmd_scheduler #(
    parameter logic [7:0]  ADDR            = 8'h00,
    parameter int unsigned HOLD_CYCLES     = 8_167_500,
    parameter int unsigned WATCHDOG_CYCLES = 7_425_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] code_in,
    input  logic        new_code_in,
    input  logic [3:0]  dec_state_in,
    output logic [7:0]  cmd_out,
    output logic        cmd_valid_out,
    input  logic        cmd_ready_in,
    output logic [7:0]  err_count_out,
    output logic [7:0]  drop_count_out,
    output logic        dec_rst_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES);
    localparam logic [31:0] WD_LAST   = 32'(WATCHDOG_CYCLES - 1);

    logic [1:0]  state;
    logic [31:0] code_q;
    logic        frame_ok_q;
    logic [31:0] hold_q;
    logic [7:0]  last_cmd_q;
    logic [7:0]  err_q;
    logic [7:0]  drop_q;
    logic [31:0] wd_q;
    logic        dec_rst_q;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  fifo_cnt;

    logic        frame_ok;
    logic        in_commit;
    logic        suppress;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full_drop;
    logic        late_drop;
    logic        err_evt;
    logic [1:0]  drop_inc;
    logic [8:0]  drop_sum;
    logic [7:0]  frame_cmd;

    assign frame_cmd = code_q[15:8];
    assign frame_ok  = (code_q[31:24] == ADDR) &&
                       (code_q[23:16] == ~code_q[31:24]) &&
                       (code_q[7:0]   == ~code_q[15:8]);

    assign in_commit = (state == ST_COMMIT);
    // A repeat of the last accepted key is ignored while the hold window is open.
    assign suppress  = (frame_cmd == last_cmd_q) && (hold_q != 32'd0);
    assign accept    = in_commit && frame_ok_q && !suppress;
    assign pop       = cmd_valid_out && cmd_ready_in;
    // A full FIFO can still take the frame if the head leaves in the same cycle.
    assign push      = accept && ((fifo_cnt != 3'd4) || pop);
    assign full_drop = accept && !push;
    assign err_evt   = in_commit && !frame_ok_q;
    assign late_drop = new_code_in && (state != ST_IDLE);
    // Both drop sources can coincide (strobe during COMMIT with a full FIFO).
    assign drop_inc  = {1'b0, full_drop} + {1'b0, late_drop};
    assign drop_sum  = {1'b0, drop_q} + {7'b0, drop_inc};

    assign cmd_valid_out  = (fifo_cnt != 3'd0);
    assign cmd_out        = cmd_valid_out ? fifo_mem[rd_ptr] : 8'h00;
    assign err_count_out  = err_q;
    assign drop_count_out = drop_q;
    assign dec_rst_out    = dec_rst_q;

    // Frame FSM
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            code_q     <= 32'd0;
            frame_ok_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_code_in) begin
                        code_q <= code_in;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    frame_ok_q <= frame_ok;
                    state      <= ST_COMMIT;
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Hold timer, last accepted command, and statistics counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_q     <= 32'd0;
            last_cmd_q <= 8'h00;
            err_q      <= 8'h00;
            drop_q     <= 8'h00;
        end else begin
            if (in_commit && frame_ok_q) begin
                hold_q <= HOLD_LOAD;
            end else if (hold_q != 32'd0) begin
                hold_q <= hold_q - 32'd1;
            end

            if (push) begin
                last_cmd_q <= frame_cmd;
            end

            if (err_evt && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end

            drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // 4-entry command FIFO
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset; cmd_out is masked while the FIFO is empty.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= frame_cmd;
        end
    end

    // Decoder watchdog: fire after WATCHDOG_CYCLES consecutive non-idle cycles.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wd_q      <= 32'd0;
            dec_rst_q <= 1'b0;
        end else if (dec_state_in == 4'd0) begin
            wd_q      <= 32'd0;
            dec_rst_q <= 1'b0;
        end else if (wd_q == WD_LAST) begin
            wd_q      <= 32'd0;
            dec_rst_q <= 1'b1;
        end else begin
            wd_q      <= wd_q + 32'd1;
            dec_rst_q <= 1'b0;
        end
    end

endmodule
